// File: rtl/door_request_sequencer_if.sv
// Handshake bundle between the request sequencer, its requesters and the door motor FSM.
//   REQ       : level requests from external sources (rising edge = one request)
//   FAULT_CLR : one-cycle pulse clearing a latched fault
//   UP_M/DOWN_M      : motor drive feedback from the door FSM
//   UP_MAX/DOWN_MAX  : open / closed limit switches
//   ACTIVATE  : one-cycle pulse into the door FSM Activate input
//   GRANT     : one-hot source of the move in progress
//   BUSY      : sequencer not idle
//   FAULT     : sticky watchdog fault
// Modports: slave = sequencer side, master = environment side.
interface door_request_sequencer_if #(
    parameter int unsigned NREQ = 3
);
    logic [NREQ-1:0] REQ;
    logic            FAULT_CLR;
    logic            UP_M;
    logic            DOWN_M;
    logic            UP_MAX;
    logic            DOWN_MAX;
    logic            ACTIVATE;
    logic [NREQ-1:0] GRANT;
    logic            BUSY;
    logic            FAULT;

    modport slave (
        input  REQ, FAULT_CLR, UP_M, DOWN_M, UP_MAX, DOWN_MAX,
        output ACTIVATE, GRANT, BUSY, FAULT
    );

    modport master (
        output REQ, FAULT_CLR, UP_M, DOWN_M, UP_MAX, DOWN_MAX,
        input  ACTIVATE, GRANT, BUSY, FAULT
    );
endinterface

// File: rtl/door_request_sequencer.sv
// Round-robin sequencer placing NREQ activation sources onto the garage door
// FSM's single Activate input, with start/travel watchdogs, post-move holdoff
// and a sticky fault.
// Ports:
//   CLK : clock
//   RST : asynchronous active-low reset
//   bus : door_request_sequencer_if.slave (requests, motor feedback, grant/status)
// Optional feature: define AUTO_CLOSE_EN to add an internal lowest-priority
// requester that closes the door after AUTO_CLOSE idle cycles fully open.
module door_request_sequencer #(
    parameter int unsigned NREQ       = 3,
    parameter int unsigned START_TO   = 16,
    parameter int unsigned MAX_TRAVEL = 1000,
    parameter int unsigned HOLDOFF    = 8,
    parameter int unsigned AUTO_CLOSE = 5000
) (
    input logic                     CLK,
    input logic                     RST,
    door_request_sequencer_if.slave bus
);
    localparam int unsigned PTR_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned START_W  = $clog2(START_TO + 1);
    localparam int unsigned TRAVEL_W = $clog2(MAX_TRAVEL + 1);
    localparam int unsigned HOLD_W   = $clog2(HOLDOFF + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_START, S_MOVING, S_HOLD, S_FAULT
    } state_t;

    state_t              state, state_nxt;
    logic [NREQ-1:0]     req_q;
    logic [NREQ-1:0]     pend, pend_nxt;
    logic [PTR_W-1:0]    rr_ptr, ptr_nxt;
    logic [START_W-1:0]  start_cnt, start_nxt;
    logic [TRAVEL_W-1:0] travel_cnt, travel_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic [NREQ-1:0]     grant_q, grant_nxt;
    logic                activate_q, activate_nxt;
    logic                busy_q, fault_q;

    logic [NREQ-1:0]     req_rise;
    logic                motion, clash;
    logic                win_vld;
    logic [PTR_W-1:0]    win_idx;
    logic [NREQ-1:0]     win_oh;
    int unsigned         slot;

    assign req_rise = bus.REQ & ~req_q;
    assign motion   = bus.UP_M | bus.DOWN_M;
    assign clash    = bus.UP_M & bus.DOWN_M;

`ifdef AUTO_CLOSE_EN
    localparam int unsigned AC_W = $clog2(AUTO_CLOSE + 1);

    logic [AC_W-1:0] ac_cnt, ac_cnt_nxt;
    logic            ac_pend, ac_pend_nxt;
    logic            ac_run;

    // Open-dwell timer; any fresh request restarts it.
    assign ac_run = (state == S_IDLE) && bus.UP_MAX && !bus.DOWN_MAX && !(|req_rise);
`else
    logic unused_ac;
    assign unused_ac = ^{bus.UP_MAX, bus.DOWN_MAX, 32'(AUTO_CLOSE)};
`endif

    // Round-robin pick: first pending source at or after the pointer.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        slot    = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            slot = (32'(rr_ptr) + k) % NREQ;
            if (!win_vld && pend[PTR_W'(slot)]) begin
                win_vld = 1'b1;
                win_idx = PTR_W'(slot);
            end
        end
        win_oh = NREQ'(1) << win_idx;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt    = state;
        pend_nxt     = pend | req_rise;
        ptr_nxt      = rr_ptr;
        start_nxt    = start_cnt;
        travel_nxt   = travel_cnt;
        hold_nxt     = hold_cnt;
        grant_nxt    = grant_q;
        activate_nxt = 1'b0;
`ifdef AUTO_CLOSE_EN
        ac_pend_nxt  = ac_pend;
        ac_cnt_nxt   = '0;
        if (ac_run) begin
            ac_cnt_nxt = (ac_cnt == AC_W'(AUTO_CLOSE)) ? ac_cnt : ac_cnt + AC_W'(1);
            if (ac_cnt == AC_W'(AUTO_CLOSE - 1)) ac_pend_nxt = 1'b1;
        end
`endif
        case (state)
            S_IDLE: begin
                grant_nxt = '0;
                if (win_vld && !clash) begin
                    state_nxt = S_ISSUE;
                    grant_nxt = win_oh;
                    pend_nxt  = pend_nxt & ~win_oh;   // same-cycle edge is consumed
                    ptr_nxt   = (32'(win_idx) + 32'd1 >= NREQ) ? '0 : win_idx + PTR_W'(1);
                end
`ifdef AUTO_CLOSE_EN
                else if (ac_pend && !clash) begin
                    state_nxt   = S_ISSUE;
                    ac_pend_nxt = 1'b0;
                end
`endif
            end
            S_ISSUE: begin
                activate_nxt = 1'b1;
                start_nxt    = '0;
                state_nxt    = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (motion) begin
                    state_nxt  = S_MOVING;
                    travel_nxt = '0;
                end else if (start_cnt >= START_W'(START_TO - 1)) begin
                    state_nxt = S_FAULT;
                    start_nxt = START_W'(START_TO);
                end else begin
                    start_nxt = start_cnt + START_W'(1);
                end
            end
            S_MOVING: begin
                if (!motion) begin
                    state_nxt = S_HOLD;
                    hold_nxt  = '0;
                end else if (travel_cnt >= TRAVEL_W'(MAX_TRAVEL - 1)) begin
                    state_nxt  = S_FAULT;
                    travel_nxt = TRAVEL_W'(MAX_TRAVEL);
                end else begin
                    travel_nxt = travel_cnt + TRAVEL_W'(1);
                end
            end
            S_HOLD: begin
                if (hold_cnt >= HOLD_W'(HOLDOFF - 1)) begin
                    state_nxt = S_IDLE;
                    grant_nxt = '0;
                end else begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            S_FAULT: begin
                if (bus.FAULT_CLR) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // Both motor drives at once is an FSM malfunction regardless of state.
        if (clash) begin
            state_nxt    = S_FAULT;
            activate_nxt = 1'b0;
        end
        if (state_nxt == S_FAULT) grant_nxt = '0;
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= S_IDLE;
            req_q      <= '0;
            pend       <= '0;
            rr_ptr     <= '0;
            start_cnt  <= '0;
            travel_cnt <= '0;
            hold_cnt   <= '0;
            grant_q    <= '0;
            activate_q <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
`ifdef AUTO_CLOSE_EN
            ac_cnt     <= '0;
            ac_pend    <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            req_q      <= bus.REQ;
            pend       <= pend_nxt;
            rr_ptr     <= ptr_nxt;
            start_cnt  <= start_nxt;
            travel_cnt <= travel_nxt;
            hold_cnt   <= hold_nxt;
            grant_q    <= grant_nxt;
            activate_q <= activate_nxt;
            busy_q     <= (state_nxt != S_IDLE);
            fault_q    <= (state_nxt == S_FAULT);
`ifdef AUTO_CLOSE_EN
            ac_cnt     <= ac_cnt_nxt;
            ac_pend    <= ac_pend_nxt;
`endif
        end
    end

    assign bus.ACTIVATE = activate_q;
    assign bus.GRANT    = grant_q;
    assign bus.BUSY     = busy_q;
    assign bus.FAULT    = fault_q;
endmodule

// File: tb/tb_door_request_sequencer.sv
// Scoreboard bench for door_request_sequencer: expected grants are queued
// when requests are driven and checked against GRANT at every ACTIVATE pulse.
module tb_door_request_sequencer;
    localparam int unsigned NREQ = 3;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    door_request_sequencer_if #(.NREQ(NREQ)) bus ();

    door_request_sequencer #(
        .NREQ(NREQ), .START_TO(16), .MAX_TRAVEL(1000), .HOLDOFF(8), .AUTO_CLOSE(5000)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int act_cnt  = 0;
    int act_hi   = 0;
    int act_cyc  = 0;
    int saved;
    logic act_prev = 1'b0;
    logic [NREQ-1:0] sb_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        tick(2);
        RST = 1'b1;
        tick(1);
    endtask

    task automatic wait_act(input int limit);
        int n;
        n = 0;
        while (!bus.ACTIVATE && n < limit) begin
            tick(1);
            n++;
        end
        check_eq("act_seen", 32'(bus.ACTIVATE), 32'd1);
    endtask

    // Door FSM stand-in: starts the motor the cycle after ACTIVATE and runs len cycles.
    task automatic run_move(input int len);
        wait_act(100);
        tick(1);
        bus.UP_M = 1'b1;
        tick(len);
        bus.UP_M = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        tick(1);
        while ((bus.BUSY || sb_q.size() != 0) && n < limit) begin
            tick(1);
            n++;
        end
        check_eq("idle_busy", 32'(bus.BUSY), 32'd0);
        check_eq("idle_sb", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic wait_fault(input int limit);
        int n;
        n = 0;
        while (!bus.FAULT && n < limit) begin
            tick(1);
            n++;
        end
        check_eq("fault_seen", 32'(bus.FAULT), 32'd1);
    endtask

    task automatic clear_fault();
        bus.FAULT_CLR = 1'b1;
        tick(1);
        bus.FAULT_CLR = 1'b0;
        check_eq("clr_fault", 32'(bus.FAULT), 32'd0);
        check_eq("clr_busy", 32'(bus.BUSY), 32'd0);
    endtask

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Scoreboard monitor: every ACTIVATE rise must match the oldest queued grant.
    initial forever begin
        @(negedge CLK);
        if (bus.ACTIVATE) act_hi++;
        if (bus.ACTIVATE && !act_prev) begin
            act_cnt++;
            act_cyc = cyc;
            if (sb_q.size() == 0) check_eq("sb_empty_at_act", 32'(sb_q.size()), 32'd1);
            else check_eq("grant_at_act", 32'(bus.GRANT), 32'(sb_q.pop_front()));
        end
        act_prev = bus.ACTIVATE;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.REQ       = '0;
        bus.FAULT_CLR = 1'b0;
        bus.UP_M      = 1'b0;
        bus.DOWN_M    = 1'b0;
        bus.UP_MAX    = 1'b0;
        bus.DOWN_MAX  = 1'b1;
        tick(3);
        check_eq("rst_grant", 32'(bus.GRANT), 32'd0);
        check_eq("rst_act", 32'(bus.ACTIVATE), 32'd0);
        check_eq("rst_busy", 32'(bus.BUSY), 32'd0);
        check_eq("rst_fault", 32'(bus.FAULT), 32'd0);
        RST = 1'b1;
        tick(2);

        // Single request, 20-cycle move, exact timing of grant/activate/holdoff.
        bus.REQ[1] = 1'b1;
        sb_q.push_back(3'b010);
        tick(1);
        check_eq("t1_grant_pre", 32'(bus.GRANT), 32'd0);
        check_eq("t1_busy_pre", 32'(bus.BUSY), 32'd0);
        tick(1);
        check_eq("t1_grant", 32'(bus.GRANT), 32'b010);
        check_eq("t1_busy", 32'(bus.BUSY), 32'd1);
        check_eq("t1_act_early", 32'(bus.ACTIVATE), 32'd0);
        tick(1);
        check_eq("t1_act", 32'(bus.ACTIVATE), 32'd1);
        tick(1);
        check_eq("t1_act_end", 32'(bus.ACTIVATE), 32'd0);
        bus.UP_M = 1'b1;
        tick(20);
        bus.UP_M = 1'b0;
        tick(8);
        check_eq("t1_hold_busy", 32'(bus.BUSY), 32'd1);
        check_eq("t1_hold_grant", 32'(bus.GRANT), 32'b010);
        tick(1);
        check_eq("t1_done_busy", 32'(bus.BUSY), 32'd0);
        check_eq("t1_done_grant", 32'(bus.GRANT), 32'd0);
        bus.REQ = '0;

        // Simultaneous requests from pointer 0, then verify the pointer wrapped to 0.
        do_reset();
        bus.REQ = 3'b101;
        sb_q.push_back(3'b001);
        sb_q.push_back(3'b100);
        run_move(20);
        run_move(20);
        wait_idle(100);
        bus.REQ = '0;
        tick(1);
        bus.REQ = 3'b110;
        sb_q.push_back(3'b010);
        sb_q.push_back(3'b100);
        run_move(20);
        run_move(20);
        wait_idle(100);
        bus.REQ = '0;
        tick(1);

        // Motor never starts: fault exactly START_TO cycles after ACTIVATE.
        bus.REQ[0] = 1'b1;
        sb_q.push_back(3'b001);
        wait_act(100);
        wait_fault(100);
        check_eq("t3_fault_lat", 32'(cyc - act_cyc), 32'd16);
        check_eq("t3_fault_grant", 32'(bus.GRANT), 32'd0);
        check_eq("t3_fault_busy", 32'(bus.BUSY), 32'd1);
        bus.REQ[2] = 1'b1;                 // latched while faulted
        sb_q.push_back(3'b100);
        tick(3);
        clear_fault();
        run_move(20);
        wait_idle(100);
        bus.REQ = '0;
        tick(1);

        // Over-travel: motor runs 1001 cycles, fault when travel count hits 1000.
        bus.REQ[1] = 1'b1;
        sb_q.push_back(3'b010);
        wait_act(100);
        tick(1);
        bus.UP_M = 1'b1;
        wait_fault(1100);
        check_eq("t4_travel_lat", 32'(cyc - act_cyc), 32'd1002);
        check_eq("t4_fault_grant", 32'(bus.GRANT), 32'd0);
        bus.UP_M = 1'b0;
        tick(2);
        clear_fault();
        tick(2);
        bus.UP_M   = 1'b1;
        bus.DOWN_M = 1'b1;
        tick(1);
        check_eq("t4_clash_fault", 32'(bus.FAULT), 32'd1);
        bus.UP_M   = 1'b0;
        bus.DOWN_M = 1'b0;
        clear_fault();
        bus.REQ = '0;
        tick(1);

        // Asynchronous reset mid-move clears outputs and pending requests.
        bus.REQ[2] = 1'b1;
        sb_q.push_back(3'b100);
        wait_act(100);
        tick(1);
        bus.UP_M = 1'b1;
        tick(5);
        bus.REQ[0] = 1'b1;
        tick(2);
        check_eq("t5_moving_busy", 32'(bus.BUSY), 32'd1);
        #2;
        RST = 1'b0;
        #1;
        check_eq("t5_rst_act", 32'(bus.ACTIVATE), 32'd0);
        check_eq("t5_rst_grant", 32'(bus.GRANT), 32'd0);
        check_eq("t5_rst_busy", 32'(bus.BUSY), 32'd0);
        check_eq("t5_rst_fault", 32'(bus.FAULT), 32'd0);
        bus.UP_M = 1'b0;
        bus.REQ  = '0;
        tick(1);
        RST = 1'b1;
        saved = act_cnt;
        tick(12);
        check_eq("t5_no_pend_busy", 32'(bus.BUSY), 32'd0);
        check_eq("t5_no_pend_act", 32'(act_cnt), 32'(saved));

`ifdef AUTO_CLOSE_EN
        // Auto-close after 5000 open idle cycles, internal grant shows GRANT=0.
        do_reset();
        bus.UP_MAX   = 1'b1;
        bus.DOWN_MAX = 1'b0;
        saved = cyc;
        sb_q.push_back(3'b000);
        wait_act(5100);
        check_eq("t6_ac_lat", 32'(cyc - saved), 32'd5002);
        check_eq("t6_ac_grant", 32'(bus.GRANT), 32'd0);
        tick(1);
        bus.UP_M     = 1'b1;
        bus.UP_MAX   = 1'b0;
        tick(20);
        bus.UP_M     = 1'b0;
        bus.DOWN_MAX = 1'b1;
        wait_idle(100);

        // A request edge one cycle short of expiry restarts the timer.
        do_reset();
        bus.UP_MAX   = 1'b1;
        bus.DOWN_MAX = 1'b0;
        tick(4998);
        bus.REQ[0] = 1'b1;
        sb_q.push_back(3'b001);
        run_move(20);
        wait_idle(100);
        saved = act_cnt;
        tick(100);
        check_eq("t6_no_early_ac", 32'(act_cnt), 32'(saved));
        sb_q.push_back(3'b000);
        wait_act(5200);
        tick(1);
        bus.UP_M   = 1'b1;
        bus.UP_MAX = 1'b0;
        tick(20);
        bus.UP_M     = 1'b0;
        bus.DOWN_MAX = 1'b1;
        wait_idle(100);
        bus.REQ = '0;
`else
        // Without the feature, a long open dwell never activates the door.
        do_reset();
        bus.UP_MAX   = 1'b1;
        bus.DOWN_MAX = 1'b0;
        saved = act_cnt;
        tick(5100);
        check_eq("t6_no_ac_act", 32'(act_cnt), 32'(saved));
        check_eq("t6_no_ac_busy", 32'(bus.BUSY), 32'd0);
`endif

        check_eq("act_width", 32'(act_hi), 32'(act_cnt));
        check_eq("sb_final", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
